// File: rtl/riscv_pipe_pkg.sv
// Shared RV32 pipeline definitions: opcodes, the canonical NOP, fetch FSM states
// and the register-usage decode used by the hazard logic.
package riscv_pipe_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2
    } fetch_state_t;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OP_JAL, OP_LUI, OP_AUIPC: used = 1'b0;
            default:                  used = 1'b1;
        endcase
        return used;
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        logic used;
        case (opcode)
            OP_R, OP_STORE, OP_BRANCH: used = 1'b1;
            default:                   used = 1'b0;
        endcase
        return used;
    endfunction

endpackage

// File: rtl/fetch_hazard_unit_hazard_detect.sv
// Load-use hazard detection: does the instruction in IF/ID read the register
// that the load currently in ID/EX is about to write?
import riscv_pipe_pkg::*;

module hazard_detect (
    input  logic       i_ifid_valid,
    input  logic [6:0] i_opcode,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_idex_mem_read,
    input  logic [4:0] i_idex_rd,
    output logic       o_hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // Source-operand match against the pending load destination; x0 never blocks.
    always_comb begin
        w_rs1_hit = uses_rs1(i_opcode) && (i_rs1 == i_idex_rd);
        w_rs2_hit = uses_rs2(i_opcode) && (i_rs2 == i_idex_rd);
        if (i_ifid_valid && i_idex_mem_read && (i_idex_rd != 5'd0)) begin
            o_hazard = w_rs1_hit || w_rs2_hit;
        end else begin
            o_hazard = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_hazard_unit.sv
// Fetch stage: PC register, IF/ID register, redirect/flush on jumps and taken
// branches, load-use bubble insertion and saturating debug counters.
import riscv_pipe_pkg::*;

module fetch_hazard_unit #(
    parameter int              WIDTH_PC    = 32,
    parameter int              WIDTH_INSTR = 32,
    parameter logic [WIDTH_PC-1:0] RESET_PC = 32'h0000_0000,
    parameter int              WIDTH_CNT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch,
    input  logic                   salta_registro,
    input  logic                   flush,
    input  logic [WIDTH_PC-1:0]    branch_target,
    input  logic [WIDTH_PC-1:0]    jalr_target,
    input  logic                   idex_mem_read,
    input  logic [4:0]             idex_rd,
    input  logic [WIDTH_INSTR-1:0] imem_instr,
    input  logic                   imem_ready,
    output logic [WIDTH_PC-1:0]    pc_out,
    output logic [WIDTH_PC-1:0]    ifid_pc,
    output logic [WIDTH_PC-1:0]    ifid_pc_plus4,
    output logic [WIDTH_INSTR-1:0] ifid_instr,
    output logic                   ifid_valid,
    output logic                   idex_bubble,
    output logic [WIDTH_CNT-1:0]   stall_count,
    output logic [WIDTH_CNT-1:0]   flush_count
);

    localparam logic [WIDTH_PC-1:0]    PC_STEP  = {{(WIDTH_PC-3){1'b0}}, 3'b100};
    localparam logic [WIDTH_PC-1:0]    JALR_MSK = {{(WIDTH_PC-1){1'b1}}, 1'b0};
    localparam logic [WIDTH_CNT-1:0]   CNT_ONE  = {{(WIDTH_CNT-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_CNT-1:0]   CNT_MAX  = {WIDTH_CNT{1'b1}};
    localparam logic [WIDTH_INSTR-1:0] NOP_W    = WIDTH_INSTR'(NOP_INSTR);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [WIDTH_PC-1:0]    r_pc;
    logic [WIDTH_PC-1:0]    r_ifid_pc;
    logic [WIDTH_INSTR-1:0] r_ifid_instr;
    logic                   r_ifid_valid;
    logic [WIDTH_CNT-1:0]   r_stall_cnt;
    logic [WIDTH_CNT-1:0]   r_flush_cnt;

    logic                   w_hazard;
    logic                   w_redirect;
    logic [WIDTH_PC-1:0]    w_pc_next;
    logic [WIDTH_PC-1:0]    w_ifid_pc_next;
    logic [WIDTH_INSTR-1:0] w_ifid_instr_next;
    logic                   w_ifid_valid_next;

    hazard_detect u_hazard_detect (
        .i_ifid_valid    (r_ifid_valid),
        .i_opcode        (r_ifid_instr[6:0]),
        .i_rs1           (r_ifid_instr[19:15]),
        .i_rs2           (r_ifid_instr[24:20]),
        .i_idex_mem_read (idex_mem_read),
        .i_idex_rd       (idex_rd),
        .o_hazard        (w_hazard)
    );

    // A stall wins over a redirect: the branch re-resolves next cycle with forwarded data.
    assign w_redirect = branch && flush && !w_hazard;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = ST_RUN;
        if (w_hazard) begin
            w_next_state = ST_LOAD_STALL;
        end else if (w_redirect) begin
            w_next_state = ST_FLUSH;
        end else begin
            w_next_state = ST_RUN;
        end
    end

    // Datapath steering: next PC and IF/ID contents in priority order.
    always_comb begin
        w_pc_next         = r_pc;
        w_ifid_pc_next    = r_ifid_pc;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_valid_next = r_ifid_valid;
        if (w_hazard) begin
            w_pc_next = r_pc;
        end else if (w_redirect) begin
            w_pc_next         = salta_registro ? (jalr_target & JALR_MSK) : branch_target;
            w_ifid_pc_next    = {WIDTH_PC{1'b0}};
            w_ifid_instr_next = NOP_W;
            w_ifid_valid_next = 1'b0;
        end else if (!imem_ready) begin
            w_ifid_pc_next    = {WIDTH_PC{1'b0}};
            w_ifid_instr_next = NOP_W;
            w_ifid_valid_next = 1'b0;
        end else begin
            w_pc_next         = r_pc + PC_STEP;
            w_ifid_pc_next    = r_pc;
            w_ifid_instr_next = imem_instr;
            w_ifid_valid_next = 1'b1;
        end
    end

    // PC, IF/ID and saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_ifid_pc    <= {WIDTH_PC{1'b0}};
            r_ifid_instr <= NOP_W;
            r_ifid_valid <= 1'b0;
            r_stall_cnt  <= {WIDTH_CNT{1'b0}};
            r_flush_cnt  <= {WIDTH_CNT{1'b0}};
        end else begin
            r_pc         <= w_pc_next;
            r_ifid_pc    <= w_ifid_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_valid <= w_ifid_valid_next;
            if (w_hazard && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_redirect && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign pc_out        = r_pc;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_pc_plus4 = r_ifid_pc + PC_STEP;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_valid    = r_ifid_valid;
    assign idex_bubble   = w_hazard && !rst;
    assign stall_count   = r_stall_cnt;
    assign flush_count   = r_flush_cnt;

endmodule

// File: tb/tb_fetch_hazard_unit.sv
// Scoreboard bench: the driver pushes the hand-computed expected outputs for each
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_fetch_hazard_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADD  = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] ADDZ = 32'h0000_01B3; // add  x3,x0,x0
    localparam logic [31:0] ADDI = 32'h0011_8113; // addi x2,x3,1 (rs2 field = 1)
    localparam logic [31:0] LUI  = 32'h0000_80B7; // lui  x1 (rs1 field = 1)
    localparam logic [31:0] BEQ  = 32'h0002_8063; // beq  x5,x0
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst, branch, salta_registro, flush, idex_mem_read, imem_ready;
    logic [31:0] branch_target, jalr_target, imem_instr;
    logic [4:0]  idex_rd;
    logic [31:0] pc_out, ifid_pc, ifid_pc_plus4, ifid_instr;
    logic        ifid_valid, idex_bubble;
    logic [3:0]  stall_count, flush_count;

    typedef struct {
        int          id;
        logic [31:0] pc, ifpc, instr;
        logic        valid, bub, chk_ifpc;
        logic [3:0]  sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   step_id = 0;

    fetch_hazard_unit #(
        .WIDTH_PC(32), .WIDTH_INSTR(32), .RESET_PC(32'h0000_0100), .WIDTH_CNT(4)
    ) dut (
        .clk(clk), .rst(rst), .branch(branch), .salta_registro(salta_registro),
        .flush(flush), .branch_target(branch_target), .jalr_target(jalr_target),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .imem_instr(imem_instr),
        .imem_ready(imem_ready), .pc_out(pc_out), .ifid_pc(ifid_pc),
        .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .idex_bubble(idex_bubble), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, id, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("pc_out", e.id, pc_out, e.pc);
                cmp("ifid_valid", e.id, {31'd0, ifid_valid}, {31'd0, e.valid});
                cmp("ifid_instr", e.id, ifid_instr, e.instr);
                cmp("idex_bubble", e.id, {31'd0, idex_bubble}, {31'd0, e.bub});
                cmp("stall_count", e.id, {28'd0, stall_count}, {28'd0, e.sc});
                cmp("flush_count", e.id, {28'd0, flush_count}, {28'd0, e.fc});
                if (e.chk_ifpc) begin
                    cmp("ifid_pc", e.id, ifid_pc, e.ifpc);
                    cmp("ifid_pc_plus4", e.id, ifid_pc_plus4, e.ifpc + 32'd4);
                end
            end
        end
    end

    task automatic step(
        input logic r, input logic br, input logic fl, input logic sr,
        input logic [31:0] bt, input logic [31:0] jt,
        input logic mr, input logic [4:0] rd, input logic [31:0] ins, input logic rdy,
        input logic [31:0] epc, input logic [31:0] eifpc, input logic [31:0] einstr,
        input logic ev, input logic ebub, input logic [3:0] esc, input logic [3:0] efc,
        input logic chk
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; branch = br; flush = fl; salta_registro = sr;
        branch_target = bt; jalr_target = jt;
        idex_mem_read = mr; idex_rd = rd; imem_instr = ins; imem_ready = rdy;
        e.id = step_id; e.pc = epc; e.ifpc = eifpc; e.instr = einstr;
        e.valid = ev; e.bub = ebub; e.sc = esc; e.fc = efc; e.chk_ifpc = chk;
        exp_q.push_back(e);
        step_id++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", step_id);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc_exp;
        rst = 1'b1; branch = 1'b0; flush = 1'b0; salta_registro = 1'b0;
        branch_target = 32'd0; jalr_target = 32'd0; idex_mem_read = 1'b0;
        idex_rd = 5'd0; imem_instr = NOP; imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        //    r br fl sr bt        jt        mr rd  ins  rdy  pc        ifpc      instr ev bub sc    fc    chk
        step(1, 0, 0, 0, 32'h0,    32'h0,    1, 1, ADD,  1, 32'h100, 32'h0,   NOP,  0, 0, 4'd0, 4'd0, 1);
        step(0, 0, 0, 0, 32'h0,    32'h0,    1, 1, ADDI, 1, 32'h100, 32'h0,   NOP,  0, 0, 4'd0, 4'd0, 0);
        step(0, 0, 0, 0, 32'h0,    32'h0,    1, 1, ADD,  1, 32'h104, 32'h100, ADDI, 1, 0, 4'd0, 4'd0, 1);
        step(0, 0, 0, 0, 32'h0,    32'h0,    1, 1, LUI,  1, 32'h108, 32'h104, ADD,  1, 1, 4'd0, 4'd0, 1);
        step(0, 1, 0, 0, 32'h400,  32'h0,    0, 1, LUI,  1, 32'h108, 32'h104, ADD,  1, 0, 4'd1, 4'd0, 1);
        step(0, 0, 0, 0, 32'h0,    32'h0,    1, 1, ADDZ, 1, 32'h10C, 32'h108, LUI,  1, 0, 4'd1, 4'd0, 1);
        step(0, 1, 1, 0, 32'h200,  32'h0,    1, 0, JUNK, 1, 32'h110, 32'h10C, ADDZ, 1, 0, 4'd1, 4'd0, 1);
        step(0, 1, 1, 1, 32'h0,    32'h305,  0, 0, JUNK, 0, 32'h200, 32'h0,   NOP,  0, 0, 4'd1, 4'd1, 0);
        step(0, 0, 0, 0, 32'h0,    32'h0,    0, 0, JUNK, 0, 32'h304, 32'h0,   NOP,  0, 0, 4'd1, 4'd2, 0);
        step(0, 0, 0, 0, 32'h0,    32'h0,    0, 0, JUNK, 0, 32'h304, 32'h0,   NOP,  0, 0, 4'd1, 4'd2, 0);
        step(0, 0, 0, 0, 32'h0,    32'h0,    0, 0, BEQ,  1, 32'h304, 32'h0,   NOP,  0, 0, 4'd1, 4'd2, 0);
        step(0, 1, 1, 0, 32'h500,  32'h0,    1, 5, JUNK, 1, 32'h308, 32'h304, BEQ,  1, 1, 4'd1, 4'd2, 1);
        step(0, 1, 1, 0, 32'h500,  32'h0,    0, 5, JUNK, 1, 32'h308, 32'h304, BEQ,  1, 0, 4'd2, 4'd2, 1);
        step(0, 0, 0, 0, 32'h0,    32'h0,    0, 0, ADD,  1, 32'h500, 32'h0,   NOP,  0, 0, 4'd2, 4'd3, 0);
        for (int k = 0; k < 20; k++) begin
            sc_exp = (2 + k > 15) ? 15 : 2 + k;
            step(0, 0, 0, 0, 32'h0, 32'h0, 1, 2, JUNK, 1, 32'h504, 32'h500, ADD, 1, 1, 4'(sc_exp), 4'd3, 1);
        end
        step(0, 0, 0, 0, 32'h0,    32'h0,    0, 0, ADD,  1, 32'h504, 32'h500, ADD,  1, 0, 4'd15, 4'd3, 1);
        step(1, 0, 0, 0, 32'h0,    32'h0,    1, 1, ADD,  1, 32'h508, 32'h504, ADD,  1, 0, 4'd15, 4'd3, 1);
        step(0, 0, 0, 0, 32'h0,    32'h0,    0, 0, NOP,  0, 32'h100, 32'h0,   NOP,  0, 0, 4'd0, 4'd0, 1);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_hazard_unit.md
Name: fetch_hazard_unit

Overview:
- Fetch-side consumer of the main control's Branch / salta_registro / flush outputs.
- Owns the PC register and the IF/ID pipeline register.
- Performs PC redirection for jal, jalr and taken branches, with flush of the wrong-path instruction.
- Detects load-use hazards and inserts a bubble into ID/EX. Keeps saturating stall and flush event counters for debug.

Parameters:
- WIDTH_PC, 32, PC and target width.
- WIDTH_INSTR, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- WIDTH_CNT, 16, width of the perf counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- branch  in  1  Branch from main control (ID stage).
- salta_registro  in  1  1 = jalr target, 0 = pc-relative target.
- flush  in  1  flush request from main control.
- branch_target  in  WIDTH_PC  ID pc + imm.
- jalr_target  in  WIDTH_PC  ID rs1 + imm.
- idex_mem_read  in  1  Mem_read of the instruction in ID/EX.
- idex_rd  in  5  destination register of the instruction in ID/EX.
- imem_instr  in  WIDTH_INSTR  instruction at pc_out (combinational IMEM).
- imem_ready  in  1  imem_instr valid this cycle.
- pc_out  out  WIDTH_PC  fetch address.
- ifid_pc  out  WIDTH_PC  PC of the instruction in IF/ID.
- ifid_pc_plus4  out  WIDTH_PC  ifid_pc + 4, used for the jal/jalr writeback.
- ifid_instr  out  WIDTH_INSTR  instruction in IF/ID.
- ifid_valid  out  1  IF/ID holds a real instruction.
- idex_bubble  out  1  force the ID/EX control fields to zero this cycle.
- stall_count  out  WIDTH_CNT  load-use stall cycles.
- flush_count  out  WIDTH_CNT  redirects taken.

Behaviour:
- Reset values, applied on the clk edge with rst=1:
  - pc_out = RESET_PC
  - ifid_instr = NOP (32'h0000_0013), ifid_pc = 0, ifid_valid = 0
  - counters = 0, state = RUN
  - idex_bubble = 0 while rst = 1
- Reset mid-stall or mid-flush discards all in-flight state.
- FSM states:
  - RUN: normal fetch.
  - LOAD_STALL: cycle after a bubble is inserted.
  - FLUSH: cycle after a redirect; IF/ID holds NOP.
  - State is informational for the bench. next_state = LOAD_STALL if hazard, else FLUSH if redirect, else RUN.
- Decode from ifid_instr:
  - rs1 = [19:15], rs2 = [24:20], opcode = [6:0].
  - rs1 is used unless opcode is jal, lui or auipc.
  - rs2 is used for R-type, S-type and SB-type only.
- hazard, combinational: ifid_valid & idex_mem_read & idex_rd != 0 & ((uses_rs1 & rs1 == idex_rd) | (uses_rs2 & rs2 == idex_rd)).
- redirect = branch & flush & ~hazard.
- Per-cycle priority, highest first:
  1. hazard: pc_out and IF/ID hold; idex_bubble = 1 in the same cycle; stall_count += 1. Any redirect from control is ignored, because it is recomputed next cycle with forwarded data.
  2. redirect: pc_out <= salta_registro ? {jalr_target[WIDTH_PC-1:1], 1'b0} : branch_target. IF/ID <= NOP with ifid_valid = 0 (one-cycle flush penalty). flush_count += 1.
  3. ~imem_ready: pc_out holds; IF/ID <= NOP with ifid_valid = 0.
  4. Otherwise: pc_out <= pc_out + 4; IF/ID <= {pc_out, imem_instr}; ifid_valid = 1.
- Arithmetic and width rules:
  - pc + 4 wraps modulo 2^WIDTH_PC.
  - ifid_pc_plus4 is combinational from ifid_pc.
- Boundary conditions:
  - Counters saturate at all-ones and do not wrap.
  - branch = 1 with flush = 0 does not redirect (jal/jalr/taken-branch always pair them).
  - A redirect while imem_ready = 0 still loads the new PC.
  - A hazard against an idle (ifid_valid = 0) IF/ID is suppressed.
  - idex_rd = x0 never stalls.
- Latency:
  - Redirect takes effect on pc_out one cycle after it is asserted.
  - The first target instruction enters IF/ID two cycles after the redirect.

Decomposition:
- Package riscv_pipe_pkg:
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
  - NOP_INSTR
  - state enum fetch_state_t
- Sub-module hazard_detect: the combinational rs1/rs2 usage decode and compare against idex_rd. Its output is the hazard signal.

Test Plan:
- Reset with RESET_PC = 32'h100, imem_ready = 1 for 3 cycles -> pc_out sequence 0x100, 0x104, 0x108; ifid_pc = 0x100 with ifid_valid = 1 after the second edge.
- Load-use: IF/ID = add x3,x1,x2, idex_mem_read = 1, idex_rd = 1 -> idex_bubble = 1 for one cycle, pc_out and ifid_instr hold, stall_count = 1; next cycle with idex_mem_read = 0 -> resumes.
- jal: branch = 1, flush = 1, salta_registro = 0, branch_target = 0x200 -> pc_out = 0x200 next cycle, ifid_instr = 0x00000013, ifid_valid = 0, flush_count = 1.
- jalr: salta_registro = 1, jalr_target = 0x305 -> pc_out = 0x304.
- Simultaneous hazard and redirect (beq x5,x0 after lw x5) -> no redirect, bubble inserted; redirect honored the following cycle.
- imem_ready = 0 for 2 cycles -> pc_out held, ifid_valid = 0; force stall_count to saturate (WIDTH_CNT = 4, 20 stalls) -> stall_count = 15.
